lab1_stream_to_mem_writer: RTL
==============================

LAB1_STREAM_TO_MEM_WRITER -- requirements
Module: lab1_stream_to_mem_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 10000, number of 32-bit words in the downstream on-chip memory.
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a transfer at base_addr.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 SHALL have port snk_data  input  8  stream byte.
REQ-008 SHALL have port snk_valid  input  1  snk_data valid.
REQ-009 SHALL have port snk_eop  input  1  last byte of packet, qualified by snk_valid.
REQ-010 SHALL have port snk_ready  output  1  byte accepted when snk_valid & snk_ready.
REQ-011 SHALL have port m_address  output  ADDR_W  Avalon-MM word address to memory.
REQ-012 SHALL have port m_writedata  output  32  Avalon-MM write data.
REQ-013 SHALL have port m_byteenable  output  4  Avalon-MM byte lanes.
REQ-014 SHALL have port m_chipselect  output  1  asserted together with m_write.
REQ-015 SHALL have port m_write  output  1  write request.
REQ-016 SHALL have port m_waitrequest  input  1  interconnect stall; write accepted when m_write & ~m_waitrequest.
REQ-017 SHALL have port busy  output  1  high from accepted start until done.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port error  output  1  sticky overflow flag, cleared by next accepted start.
REQ-020 SHALL have port word_count  output  ADDR_W+1  words written in current/last transfer.

Function
REQ-021 SHALL implement states IDLE, COLLECT, WRITE, DRAIN, DONE.
REQ-022 IDLE: start accepted only in IDLE; start in any other state is ignored.
REQ-023 Accepted start with base_addr < DEPTH: load address, clear lanes, word_count, error; go COLLECT next cycle.
REQ-024 Accepted start with base_addr >= DEPTH: set error, go DONE; no memory write.
REQ-025 snk_ready SHALL be 1 only in COLLECT and DRAIN, 0 otherwise.
REQ-026 Packing little-endian: k-th accepted byte of a word (k=0..3) goes to m_writedata[8k+7:8k], byteenable bit k set.
REQ-027 On 4th byte or byte with snk_eop accepted in cycle N, m_write and m_chipselect SHALL be high from cycle N+1 (WRITE).
REQ-028 Partial word (eop after 1-3 bytes): byteenable has only filled lanes (0001/0011/0111); unused data lanes 0.
REQ-029 While m_waitrequest=1, m_address, m_writedata, m_byteenable, m_write SHALL hold stable.
REQ-030 On write acceptance: word_count+1; m_write/m_chipselect low next cycle; address+1; lanes cleared.
REQ-031 After acceptance: word containing eop -> DONE; else if address+1 = DEPTH -> set error, go DRAIN; else COLLECT.
REQ-032 DRAIN: accept and discard bytes, no writes, until byte with snk_eop accepted, then DONE.
REQ-033 DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-034 busy SHALL be 1 in COLLECT, WRITE, DRAIN.
REQ-035 word_count and error SHALL hold after DONE until next accepted start.
REQ-036 Address arithmetic SHALL never wrap past DEPTH-1; no write issued to address >= DEPTH.

Reset
REQ-037 reset_n=0 SHALL immediately force IDLE and all outputs to 0 (snk_ready, m_write, m_chipselect, m_byteenable, m_writedata, m_address, busy, done, error, word_count).
REQ-038 Reset mid-WRITE SHALL drop m_write asynchronously; pending partial word is discarded; no resumption after release.
REQ-039 First start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-040 base_addr=0x0010, bytes 01..08, eop on 08, no wait -> writes 0x04030201 @0x0010 BE 1111, 0x08070605 @0x0011 BE 1111; done pulse; word_count=2; error=0.
REQ-041 5 bytes 01..05, eop on 05 -> 2nd write @base+1 data 0x00000005 BE 0001; word_count=2.
REQ-042 m_waitrequest high 3 cycles during first write -> m_write/address/data stable 4 cycles, snk_ready=0, one write counted.
REQ-043 base_addr=9999, 6 bytes, eop on 6th -> one write @9999 BE 1111, error=1, bytes 5-6 accepted and discarded, done, word_count=1.
REQ-044 start during busy and start with base_addr=10000 -> first ignored; second gives done next-but-one cycle, error=1, no write.
REQ-045 reset_n pulsed low while m_write=1 -> all outputs 0 immediately; next start after release behaves as REQ-040.

Source files
------------

// File: rtl/lab1_stream_to_mem_writer.sv
`timescale 1ns/1ps
// Packs a byte stream little-endian into 32-bit words and writes them over Avalon-MM.
// Latency: a word's m_write rises the cycle after its 4th (or eop) byte is accepted.
// Backpressure: snk_ready is low while a write is pending; m_waitrequest freezes the bus.
module lab1_stream_to_mem_writer #(
    parameter int DEPTH  = 10000,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [3:0]        r_be;
    logic [1:0]        r_lane;
    logic              r_last;
    logic              r_wr;
    logic              r_rdy;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_wcnt;

    logic              w_accept;
    logic              w_wr_ack;
    logic              w_base_ok;
    logic              w_at_end;

    assign w_accept  = snk_valid & r_rdy;
    assign w_wr_ack  = r_wr & ~m_waitrequest;
    assign w_base_ok = ({1'b0, base_addr} < LP_DEPTH);
    assign w_at_end  = (({1'b0, r_addr} + (ADDR_W+1)'(1)) == LP_DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
            r_lane  <= '0;
            r_last  <= 1'b0;
            r_wr    <= 1'b0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wcnt <= '0;
                        r_data <= '0;
                        r_be   <= '0;
                        r_lane <= '0;
                        r_last <= 1'b0;
                        if (w_base_ok) begin
                            r_addr  <= base_addr;
                            r_err   <= 1'b0;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_COLLECT;
                        end else begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_data[8*r_lane +: 8] <= snk_data;
                        r_be[r_lane]          <= 1'b1;
                        r_lane                <= r_lane + 2'd1;
                        if (r_lane == 2'd3 || snk_eop) begin
                            r_last  <= snk_eop;
                            r_wr    <= 1'b1;
                            r_rdy   <= 1'b0;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wr_ack) begin
                        r_wr   <= 1'b0;
                        r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
                        r_data <= '0;
                        r_be   <= '0;
                        r_lane <= '0;
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_at_end) begin
                            // Memory full mid-packet: swallow the rest of the packet.
                            r_err   <= 1'b1;
                            r_rdy   <= 1'b1;
                            r_state <= S_DRAIN;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_rdy   <= 1'b1;
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && snk_eop) begin
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snk_ready    = r_rdy;
    assign m_address    = r_addr;
    assign m_writedata  = r_data;
    assign m_byteenable = r_be;
    assign m_chipselect = r_wr;
    assign m_write      = r_wr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_err;
    assign word_count   = r_wcnt;

endmodule
